// File: rtl/spi_master_if.sv
// Bundle between the SPI master and its user: start/done handshake plus
// the four SPI pins. "master" is the controller's view, "slave" the user's.
interface spi_master_if #(
  parameter int WORD_SIZE = 8
);
  logic                 start_i;
  logic [WORD_SIZE-1:0] data_tx_i;
  logic [WORD_SIZE-1:0] data_rx_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 sck_o;
  logic                 sdo_o;
  logic                 sdi_i;
  logic                 cs_o;

  modport master (
    input  start_i, data_tx_i, sdi_i,
    output data_rx_o, busy_o, done_o, sck_o, sdo_o, cs_o
  );

  modport slave (
    output start_i, data_tx_i, sdi_i,
    input  data_rx_o, busy_o, done_o, sck_o, sdo_o, cs_o
  );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 initiator: one WORD_SIZE word per start, MSB first, full duplex.
// sck half-period is CLK_DIV system clocks; cs_o is active high.
module spi_master #(
  parameter int WORD_SIZE = 8,
  parameter int CLK_DIV   = 2
) (
  input  logic         clk_i,
  input  logic         nreset_i,
  spi_master_if.master bus
);

  localparam int CNT_W = $clog2(WORD_SIZE) + 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BITS     = CNT_W'(WORD_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_TRANSFER,
    S_HOLD,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [CNT_W-1:0]     bit_q, bit_d;
  logic [WORD_SIZE-1:0] tx_q, tx_d;
  logic [WORD_SIZE-1:0] rx_q, rx_d;
  logic [WORD_SIZE-1:0] data_rx_q, data_rx_d;
  logic                 sck_q, sck_d;
  logic                 cs_q, cs_d;
  logic                 sdo_q, sdo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 tick;
  logic [CNT_W-1:0]     bit_nxt;

  assign bit_nxt = bit_q + CNT_W'(1);

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      data_rx_q <= '0;
      sck_q     <= 1'b0;
      cs_q      <= 1'b0;
      sdo_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      data_rx_q <= data_rx_d;
      sck_q     <= sck_d;
      cs_q      <= cs_d;
      sdo_q     <= sdo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Divider only runs while the bus is active so every phase starts aligned.
  always_comb begin
    div_d = '0;
    tick  = 1'b0;
    if (state_q inside {S_SETUP, S_TRANSFER, S_HOLD}) begin
      if (div_q == DIV_LAST) begin
        tick = 1'b1;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    data_rx_d = data_rx_q;
    sck_d     = sck_q;
    cs_d      = cs_q;
    sdo_d     = sdo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          tx_d    = bus.data_tx_i;
          rx_d    = '0;
          bit_d   = '0;
          cs_d    = 1'b1;
          sdo_d   = bus.data_tx_i[WORD_SIZE-1];
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end
      end

      // The end of setup is the first sck rising edge, so sdi is sampled here too.
      S_SETUP: begin
        if (tick) begin
          sck_d   = 1'b1;
          rx_d    = {rx_q[WORD_SIZE-2:0], bus.sdi_i};
          state_d = S_TRANSFER;
        end
      end

      S_TRANSFER: begin
        if (tick) begin
          if (sck_q) begin
            sck_d = 1'b0;
            bit_d = bit_nxt;
            if (bit_nxt < BITS) begin
              sdo_d = tx_q[WORD_SIZE-2];
              tx_d  = {tx_q[WORD_SIZE-2:0], 1'b0};
            end else begin
              sdo_d = 1'b0;
            end
          end else if (bit_q == BITS) begin
            state_d = S_HOLD;
          end else begin
            sck_d = 1'b1;
            rx_d  = {rx_q[WORD_SIZE-2:0], bus.sdi_i};
          end
        end
      end

      S_HOLD: begin
        if (tick) begin
          cs_d      = 1'b0;
          data_rx_d = rx_q;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.data_rx_o = data_rx_q;
  assign bus.busy_o    = busy_q;
  assign bus.done_o    = done_q;
  assign bus.sck_o     = sck_q;
  assign bus.sdo_o     = sdo_q;
  assign bus.cs_o      = cs_q;

endmodule
